// File: rtl/riscv_core_dcache_pkg.sv
// riscv_core_dcache_pkg
//   Shared definitions for the L1 data-cache controller. The cache is
//   direct-mapped with 128 sets of 32-byte blocks over a 64-bit byte address:
//     addr[63:12] tag | addr[11:5] set index | addr[4:0] byte offset
//   This package provides the field widths, the slice positions, the
//   controller state type and a helper that rebuilds a block-aligned address.
package riscv_core_dcache_pkg;

  localparam int ADDR_WIDTH       = 64;
  localparam int INDEX_WIDTH      = 7;
  localparam int OFFSET_WIDTH     = 5;
  localparam int TAG_WIDTH        = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int NUM_SETS         = 1 << INDEX_WIDTH;
  localparam int INDEX_LSB        = OFFSET_WIDTH;
  localparam int TAG_LSB          = OFFSET_WIDTH + INDEX_WIDTH;
  localparam int BLOCK_ADDR_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;

  typedef logic [ADDR_WIDTH-1:0]       addr_t;
  typedef logic [TAG_WIDTH-1:0]        tag_t;
  typedef logic [INDEX_WIDTH-1:0]      index_t;
  typedef logic [BLOCK_ADDR_WIDTH-1:0] block_addr_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } dcache_state_e;

  // Byte address of the first byte of block {tag, index}.
  function automatic addr_t block_addr(input tag_t tag, input index_t idx);
    return {tag, idx, {OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/riscv_core_dcache_tag_array.sv
// riscv_core_dcache_tag_array
//   Tag, valid and dirty storage for the 128 sets of the data cache.
//   Read is asynchronous so a hit can be resolved in the request cycle.
//   Writes happen at the clock edge; reset clears every entry asynchronously.
// Ports
//   i_clk, i_rst_n     clock, async active-low reset
//   i_rd_idx           set being looked up
//   o_rd_tag/valid/dirty  contents of that set
//   i_wr_idx           set being written
//   i_install_en       install i_install_tag: valid=1, dirty=0 (refill done)
//   i_set_dirty_en     mark the set dirty (store hit)
module riscv_core_dcache_tag_array
  import riscv_core_dcache_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  index_t i_rd_idx,
  output tag_t   o_rd_tag,
  output logic   o_rd_valid,
  output logic   o_rd_dirty,
  input  index_t i_wr_idx,
  input  logic   i_install_en,
  input  tag_t   i_install_tag,
  input  logic   i_set_dirty_en
);

  tag_t                tag_q [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  assign o_rd_tag   = tag_q[i_rd_idx];
  assign o_rd_valid = valid_q[i_rd_idx];
  assign o_rd_dirty = dirty_q[i_rd_idx];

  // NOTE: this storage is built from flops, not an SRAM macro, precisely so it
  // can be cleared in reset; the cache must come up with every set invalid.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_q   <= '{default: '0};
      valid_q <= '0;
      dirty_q <= '0;
    end else if (i_install_en) begin
      tag_q[i_wr_idx]   <= i_install_tag;
      valid_q[i_wr_idx] <= 1'b1;
      dirty_q[i_wr_idx] <= 1'b0;
    end else if (i_set_dirty_en) begin
      dirty_q[i_wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/riscv_core_dcache_controller.sv
// riscv_core_dcache_controller
//   Sequencing FSM for the direct-mapped, write-back, write-allocate L1 data
//   cache. Looks up the core request in the tag array, completes hits in the
//   same cycle, and on a miss writes back a dirty victim (if any) and refills
//   the block over AXI while stalling the core.
// Ports
//   i_clk, i_rst_n        clock, async active-low reset
//   i_req_valid/i_req_we  core request (held while o_stall=1), 1=store
//   i_addr_from_core      request byte address
//   o_stall               core must hold its request
//   o_rd_en/o_wr_en       data memory read / write enable
//   o_block_replace       with o_wr_en: write the AXI refill block
//   o_axi_rd_req          refill request, held until i_axi_rd_done
//   o_axi_wr_req          writeback request, held until i_axi_wr_done
//   o_axi_addr            block-aligned address of the current AXI request
//   i_axi_rd_done         refill block present on the data-memory AXI input
//   i_axi_wr_done         writeback accepted
module riscv_core_dcache_controller
  import riscv_core_dcache_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_addr_from_core,
  output logic                  o_stall,
  output logic                  o_rd_en,
  output logic                  o_wr_en,
  output logic                  o_block_replace,
  output logic                  o_axi_rd_req,
  output logic                  o_axi_wr_req,
  output logic [ADDR_WIDTH-1:0] o_axi_addr,
  input  logic                  i_axi_rd_done,
  input  logic                  i_axi_wr_done
);

  dcache_state_e state_q;
  block_addr_t   miss_blk_q;   // block address captured when the miss is detected

  index_t req_idx;
  tag_t   req_tag;
  index_t miss_idx;
  tag_t   miss_tag;
  index_t arr_idx;
  tag_t   arr_tag;
  logic   arr_valid;
  logic   arr_dirty;
  logic   hit;
  logic   req_hit;
  logic   req_miss;
  logic   install_en;
  logic   set_dirty_en;
  logic   unused_offset;

  assign req_idx  = i_addr_from_core[TAG_LSB-1:INDEX_LSB];
  assign req_tag  = i_addr_from_core[ADDR_WIDTH-1:TAG_LSB];
  assign miss_idx = miss_blk_q[INDEX_WIDTH-1:0];
  assign miss_tag = miss_blk_q[BLOCK_ADDR_WIDTH-1:INDEX_WIDTH];

  // The byte offset does not affect lookup; the data memory decodes it.
  assign unused_offset = ^i_addr_from_core[OFFSET_WIDTH-1:0];

  // While a miss is in flight the core may drop or change its request, so the
  // array is indexed by the captured miss address outside IDLE.
  assign arr_idx = (state_q == IDLE) ? req_idx : miss_idx;

  assign hit          = arr_valid && (arr_tag == req_tag);
  assign req_hit      = (state_q == IDLE) && i_req_valid && hit;
  assign req_miss     = (state_q == IDLE) && i_req_valid && !hit;
  assign install_en   = (state_q == REFILL) && i_axi_rd_done;
  assign set_dirty_en = req_hit && i_req_we;

  riscv_core_dcache_tag_array u_tag_array (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_rd_idx       (arr_idx),
    .o_rd_tag       (arr_tag),
    .o_rd_valid     (arr_valid),
    .o_rd_dirty     (arr_dirty),
    .i_wr_idx       (arr_idx),
    .i_install_en   (install_en),
    .i_install_tag  (miss_tag),
    .i_set_dirty_en (set_dirty_en)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      miss_blk_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_miss) begin
            miss_blk_q <= i_addr_from_core[ADDR_WIDTH-1:OFFSET_WIDTH];
            state_q    <= arr_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: if (i_axi_wr_done) state_q <= REFILL;
        REFILL:    if (i_axi_rd_done) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and the live request rather than
  // registered: a hit must complete in the cycle it is presented.
  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // the block leaves one unassigned, which would infer a latch.
    o_stall         = 1'b0;
    o_rd_en         = 1'b0;
    o_wr_en         = 1'b0;
    o_block_replace = 1'b0;
    o_axi_rd_req    = 1'b0;
    o_axi_wr_req    = 1'b0;
    o_axi_addr      = '0;
    case (state_q)
      IDLE: begin
        if (req_hit) begin
          o_rd_en = !i_req_we;
          o_wr_en = i_req_we;
        end else if (req_miss) begin
          o_stall    = 1'b1;
          o_axi_addr = arr_dirty ? block_addr(arr_tag, req_idx)
                                 : block_addr(req_tag, req_idx);
        end
      end
      WRITEBACK: begin
        o_stall      = 1'b1;
        o_rd_en      = 1'b1;   // victim block streams out of the data memory
        o_axi_wr_req = 1'b1;
        o_axi_addr   = block_addr(arr_tag, miss_idx);
      end
      REFILL: begin
        o_stall      = 1'b1;
        o_axi_rd_req = 1'b1;
        o_axi_addr   = block_addr(miss_tag, miss_idx);
        if (i_axi_rd_done) begin
          o_wr_en         = 1'b1;
          o_block_replace = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_riscv_core_dcache_controller.sv
// Self-checking bench for riscv_core_dcache_controller. The stimulus thread
// pushes the expected event sequence (AXI writeback start, refill start,
// block replace, core access completion) into a queue; an independent monitor
// samples on the falling edge and pops/compares each event the DUT produces.
module tb_riscv_core_dcache_controller;

  typedef enum logic [1:0] {EV_ACC, EV_WB, EV_RF, EV_REPL} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [63:0] addr;
    logic        we;
  } ev_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        i_req_we;
  logic [63:0] i_addr_from_core;
  logic        o_stall;
  logic        o_rd_en;
  logic        o_wr_en;
  logic        o_block_replace;
  logic        o_axi_rd_req;
  logic        o_axi_wr_req;
  logic [63:0] o_axi_addr;
  logic        i_axi_rd_done;
  logic        i_axi_wr_done;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  logic axi_auto;
  int   lat;
  logic prev_wr_req = 1'b0;
  logic prev_rd_req = 1'b0;

  // Reference model of the tag state, used for the full-index sweep.
  logic        m_valid [128];
  logic        m_dirty [128];
  logic [51:0] m_tag   [128];

  riscv_core_dcache_controller dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_req_valid      (i_req_valid),
    .i_req_we         (i_req_we),
    .i_addr_from_core (i_addr_from_core),
    .o_stall          (o_stall),
    .o_rd_en          (o_rd_en),
    .o_wr_en          (o_wr_en),
    .o_block_replace  (o_block_replace),
    .o_axi_rd_req     (o_axi_rd_req),
    .o_axi_wr_req     (o_axi_wr_req),
    .o_axi_addr       (o_axi_addr),
    .i_axi_rd_done    (i_axi_rd_done),
    .i_axi_wr_done    (i_axi_wr_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(input ev_kind_e k, input logic [63:0] a, input logic we);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.we   = we;
    return e;
  endfunction

  task automatic push(input ev_kind_e k, input logic [63:0] a, input logic we);
    exp_q.push_back(mk_ev(k, a, we));
  endtask

  task automatic observe(input ev_t act);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got kind=%0d addr=0x%0h we=%0b, expected no event",
               int'(act.kind), act.addr, act.we);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL sb_event: got kind=%0d addr=0x%0h we=%0b, expected kind=%0d addr=0x%0h we=%0b",
                 int'(act.kind), act.addr, act.we, int'(e.kind), e.addr, e.we);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_axi_wr_req && !prev_wr_req) begin
        observe(mk_ev(EV_WB, o_axi_addr, 1'b0));
        check("wb_mem_enables", {62'd0, o_rd_en, o_wr_en}, 64'd2);
      end
      if (o_axi_rd_req && !prev_rd_req)
        observe(mk_ev(EV_RF, o_axi_addr, 1'b0));
      if (o_wr_en && o_block_replace)
        observe(mk_ev(EV_REPL, o_axi_addr, 1'b0));
      if (i_req_valid && !o_stall) begin
        observe(mk_ev(EV_ACC, i_addr_from_core, o_wr_en));
        check("acc_mem_enables", {62'd0, o_rd_en, o_wr_en}, {62'd0, !i_req_we, i_req_we});
      end
    end
    prev_wr_req = o_axi_wr_req;
    prev_rd_req = o_axi_rd_req;
  end

  // AXI responder: pulses done 'lat' cycles after the request was first seen.
  initial begin
    int wr_cnt = 0;
    int rd_cnt = 0;
    forever begin
      @(posedge i_clk);
      #1;
      if (axi_auto) begin
        i_axi_wr_done = 1'b0;
        i_axi_rd_done = 1'b0;
        if (o_axi_wr_req) begin
          if (wr_cnt >= lat) begin i_axi_wr_done = 1'b1; wr_cnt = 0; end
          else wr_cnt++;
        end else wr_cnt = 0;
        if (o_axi_rd_req) begin
          if (rd_cnt >= lat) begin i_axi_rd_done = 1'b1; rd_cnt = 0; end
          else rd_cnt++;
        end else rd_cnt = 0;
      end
    end
  end

  // Presents one request and holds it until it completes; returns the number
  // of stalled cycles. Called and returns 1 time unit after a rising edge.
  task automatic access(input logic [63:0] a, input logic we, output int stalls);
    logic done = 1'b0;
    stalls = 0;
    i_req_valid      = 1'b1;
    i_req_we         = we;
    i_addr_from_core = a;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (!o_stall) begin done = 1'b1; break; end
      stalls++;
    end
    check("access_completes", {63'd0, done}, 64'd1);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  // Predicts the event sequence and stall count from the model, then runs it.
  task automatic model_access(input logic [63:0] a, input logic we);
    logic [6:0]  idx = a[11:5];
    logic [51:0] tg  = a[63:12];
    int exp_stalls = 0;
    int stalls;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      exp_stalls = lat + 2;
      if (m_valid[idx] && m_dirty[idx]) begin
        push(EV_WB, {m_tag[idx], idx, 5'd0}, 1'b0);
        exp_stalls = 2 * lat + 3;
      end
      push(EV_RF, {a[63:5], 5'd0}, 1'b0);
      push(EV_REPL, {a[63:5], 5'd0}, 1'b0);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    push(EV_ACC, a, we);
    if (we) m_dirty[idx] = 1'b1;
    access(a, we, stalls);
    check("model_stalls", stalls, exp_stalls);
  endtask

  initial begin
    int stalls;
    i_rst_n          = 1'b0;
    i_req_valid      = 1'b0;
    i_req_we         = 1'b0;
    i_addr_from_core = '0;
    i_axi_rd_done    = 1'b0;
    i_axi_wr_done    = 1'b0;
    axi_auto         = 1'b1;
    lat              = 2;

    @(negedge i_clk);
    check("reset_ctrl_outputs", {58'd0, o_stall, o_rd_en, o_wr_en, o_block_replace,
                                 o_axi_rd_req, o_axi_wr_req}, 64'd0);
    check("reset_axi_addr", o_axi_addr, 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("idle_outputs", {58'd0, o_stall, o_rd_en, o_wr_en, o_block_replace,
                           o_axi_rd_req, o_axi_wr_req}, 64'd0);
    @(posedge i_clk);
    #1;

    // 1: cold load miss, clean refill, then hit.
    push(EV_RF,   64'h1000, 1'b0);
    push(EV_REPL, 64'h1000, 1'b0);
    push(EV_ACC,  64'h1000, 1'b0);
    access(64'h1000, 1'b0, stalls);
    check("t1_clean_miss_stalls", stalls, 4);

    // 2: store hit in the same block, zero latency, marks it dirty.
    push(EV_ACC, 64'h1008, 1'b1);
    access(64'h1008, 1'b1, stalls);
    check("t2_store_hit_stalls", stalls, 0);

    // 3: conflicting load at index 0 writes back 0x1000, then refills 0x2000.
    push(EV_WB,   64'h1000, 1'b0);
    push(EV_RF,   64'h2000, 1'b0);
    push(EV_REPL, 64'h2000, 1'b0);
    push(EV_ACC,  64'h2000, 1'b0);
    access(64'h2000, 1'b0, stalls);
    check("t3_dirty_miss_stalls", stalls, 7);

    // 4: done pulses while idle must be ignored.
    axi_auto      = 1'b0;
    i_axi_rd_done = 1'b1;
    i_axi_wr_done = 1'b1;
    @(negedge i_clk);
    check("t4_spurious_done", {58'd0, o_stall, o_rd_en, o_wr_en, o_block_replace,
                               o_axi_rd_req, o_axi_wr_req}, 64'd0);
    @(posedge i_clk);
    #1;
    i_axi_rd_done = 1'b0;
    i_axi_wr_done = 1'b0;
    push(EV_ACC, 64'h2000, 1'b0);
    access(64'h2000, 1'b0, stalls);
    check("t4_still_hit", stalls, 0);

    // 5: reset asserted while a refill is outstanding.
    push(EV_RF, 64'h3000, 1'b0);
    i_req_valid      = 1'b1;
    i_req_we         = 1'b0;
    i_addr_from_core = 64'h3000;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      if (o_axi_rd_req) break;
    end
    check("t5_in_refill", {63'd0, o_axi_rd_req}, 64'd1);
    #1;
    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    #1;
    check("t5_async_reset_outputs", {58'd0, o_stall, o_rd_en, o_wr_en, o_block_replace,
                                     o_axi_rd_req, o_axi_wr_req}, 64'd0);
    check("t5_async_reset_addr", o_axi_addr, 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n  = 1'b1;
    axi_auto = 1'b1;
    for (int i = 0; i < 128; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    push(EV_RF,   64'h2000, 1'b0);
    push(EV_REPL, 64'h2000, 1'b0);
    push(EV_ACC,  64'h2000, 1'b0);
    access(64'h2000, 1'b0, stalls);
    check("t5_miss_after_reset", stalls, 4);
    m_valid[0] = 1'b1;
    m_tag[0]   = 52'h2;

    // 6: sweep every index: refill each once, then hit all, then evict some.
    for (int i = 0; i < 128; i++) begin
      lat = i % 3;
      model_access(64'h10000 | (64'(i) << 5) | (64'(i % 4) << 3), i[0]);
    end
    for (int i = 0; i < 128; i++)
      model_access(64'h10000 | (64'(i) << 5), !i[0]);
    for (int i = 0; i < 16; i++) begin
      lat = (i + 1) % 3;
      model_access(64'h20000 | (64'(i) << 5), 1'b0);
    end

    repeat (4) @(negedge i_clk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
